// File: rtl/mem_arb_pkg.sv
// Shared types and limits for the memory-port arbiter (mem_arbiter, mem_arb_pick).
package mem_arb_pkg;

    localparam int unsigned DATA_WIDTH      = 32;
    localparam int unsigned MEM_LATENCY_MIN = 1;
    localparam int unsigned MEM_LATENCY_MAX = 15;

    typedef enum logic {
        OWN_IF = 1'b0,
        OWN_LS = 1'b1
    } owner_e;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2
    } state_e;

endpackage

// File: rtl/mem_arb_pick.sv
// Combinational winner selection between fetch and load/store requests.
// ARB_RR_EN selects round-robin on conflicts; otherwise LS has fixed priority.
module mem_arb_pick
    import mem_arb_pkg::*;
(
    input  logic if_req,
    input  logic ls_req,
    input  logic last_grant,
    output logic winner,
    output logic any
);

    assign any = if_req | ls_req;

`ifdef ARB_RR_EN
    // On conflict the requester that did not win last time goes next.
    always_comb begin
        winner = OWN_LS;
        if (if_req && ls_req) begin
            winner = (last_grant == OWN_IF) ? OWN_LS : OWN_IF;
        end else if (if_req) begin
            winner = OWN_IF;
        end
    end
`else
    logic w_unused_last_grant;
    assign w_unused_last_grant = last_grant;
    assign winner = ls_req ? OWN_LS : OWN_IF;
`endif

endmodule

// File: rtl/mem_arbiter.sv
// Shares the single memory port between fetch (IF) and load/store (LS): issue, fixed
// read-latency wait, read-data return. Define ARB_RR_EN for round-robin arbitration.
module mem_arbiter
    import mem_arb_pkg::*;
#(
    parameter int unsigned ADDR_WIDTH  = 32,
    parameter int unsigned MEM_LATENCY = 1
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  if_req,
    input  logic [ADDR_WIDTH-1:0] if_addr,
    output logic                  if_gnt,
    output logic                  if_rvalid,
    input  logic                  ls_req,
    input  logic                  ls_we,
    input  logic [ADDR_WIDTH-1:0] ls_addr,
    input  logic [DATA_WIDTH-1:0] ls_wdata,
    output logic                  ls_gnt,
    output logic                  ls_rvalid,
    output logic [DATA_WIDTH-1:0] rdata,
    output logic [ADDR_WIDTH-1:0] addr,
    output logic [DATA_WIDTH-1:0] data_core_mem,
    output logic                  we,
    output logic                  re,
    input  logic [DATA_WIDTH-1:0] data_mem_core
);

    localparam int unsigned LAT_W = $clog2(MEM_LATENCY + 1);

    state_e                r_state, w_state_nxt;
    logic                  r_owner, w_owner_nxt;
    logic [LAT_W-1:0]      r_lat_cnt, w_lat_cnt_nxt;
    logic [ADDR_WIDTH-1:0] r_addr, w_addr_nxt;
    logic [DATA_WIDTH-1:0] r_wdata, w_wdata_nxt;
    logic [DATA_WIDTH-1:0] r_rdata, w_rdata_nxt;
    logic                  r_we, w_we_nxt;
    logic                  r_re, w_re_nxt;
    logic                  r_if_rvalid, w_if_rvalid_nxt;
    logic                  r_ls_rvalid, w_ls_rvalid_nxt;
    logic                  w_if_gnt, w_ls_gnt;
    logic                  w_winner, w_any, w_grant, w_last_grant;

    mem_arb_pick u_pick (
        .if_req     (if_req),
        .ls_req     (ls_req),
        .last_grant (w_last_grant),
        .winner     (w_winner),
        .any        (w_any)
    );

    assign w_grant = (r_state == IDLE) && w_any;

`ifdef ARB_RR_EN
    logic r_last_grant;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_last_grant <= OWN_IF;
        end else if (w_grant) begin
            r_last_grant <= w_winner;
        end
    end

    assign w_last_grant = r_last_grant;
`else
    assign w_last_grant = OWN_IF;
`endif

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state logic
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            IDLE:    if (w_any) w_state_nxt = ISSUE;
            ISSUE:   w_state_nxt = r_we ? IDLE : WAIT;
            WAIT:    if (r_lat_cnt == '0) w_state_nxt = IDLE;
            default: w_state_nxt = IDLE;
        endcase
    end

    // Output logic: grants are combinational, everything else is the next register value
    always_comb begin
        w_if_gnt        = 1'b0;
        w_ls_gnt        = 1'b0;
        w_owner_nxt     = r_owner;
        w_lat_cnt_nxt   = r_lat_cnt;
        w_addr_nxt      = r_addr;
        w_wdata_nxt     = r_wdata;
        w_rdata_nxt     = r_rdata;
        w_we_nxt        = 1'b0;
        w_re_nxt        = 1'b0;
        w_if_rvalid_nxt = 1'b0;
        w_ls_rvalid_nxt = 1'b0;
        case (r_state)
            IDLE: begin
                if (w_any) begin
                    w_owner_nxt = w_winner;
                    if (w_winner == OWN_LS) begin
                        w_ls_gnt    = 1'b1;
                        w_addr_nxt  = ls_addr;
                        w_wdata_nxt = ls_wdata;
                        w_we_nxt    = ls_we;
                        w_re_nxt    = ~ls_we;
                    end else begin
                        w_if_gnt   = 1'b1;
                        w_addr_nxt = if_addr;
                        w_re_nxt   = 1'b1;
                    end
                end
            end
            ISSUE: begin
                if (!r_we) w_lat_cnt_nxt = LAT_W'(MEM_LATENCY - 1);
            end
            WAIT: begin
                if (r_lat_cnt == '0) begin
                    w_rdata_nxt     = data_mem_core;
                    w_if_rvalid_nxt = (r_owner == OWN_IF);
                    w_ls_rvalid_nxt = (r_owner == OWN_LS);
                end else begin
                    w_lat_cnt_nxt = r_lat_cnt - LAT_W'(1);
                end
            end
            default: ;
        endcase
    end

    // Datapath and registered outputs; reset drops any in-flight read
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_owner     <= OWN_IF;
            r_lat_cnt   <= '0;
            r_addr      <= '0;
            r_wdata     <= '0;
            r_rdata     <= '0;
            r_we        <= 1'b0;
            r_re        <= 1'b0;
            r_if_rvalid <= 1'b0;
            r_ls_rvalid <= 1'b0;
        end else begin
            r_owner     <= w_owner_nxt;
            r_lat_cnt   <= w_lat_cnt_nxt;
            r_addr      <= w_addr_nxt;
            r_wdata     <= w_wdata_nxt;
            r_rdata     <= w_rdata_nxt;
            r_we        <= w_we_nxt;
            r_re        <= w_re_nxt;
            r_if_rvalid <= w_if_rvalid_nxt;
            r_ls_rvalid <= w_ls_rvalid_nxt;
        end
    end

    assign if_gnt        = rst_n & w_if_gnt;
    assign ls_gnt        = rst_n & w_ls_gnt;
    assign if_rvalid     = r_if_rvalid;
    assign ls_rvalid     = r_ls_rvalid;
    assign rdata         = r_rdata;
    assign addr          = r_addr;
    assign data_core_mem = r_wdata;
    assign we            = r_we;
    assign re            = r_re;

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter with a cycle-schedule reference model (honours ARB_RR_EN).
module tb_mem_arbiter;

    localparam int LAT  = 2;
    localparam int RING = 64;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        if_req = 1'b0;
    logic [31:0] if_addr = '0;
    logic        if_gnt, if_rvalid;
    logic        ls_req = 1'b0;
    logic        ls_we = 1'b0;
    logic [31:0] ls_addr = '0;
    logic [31:0] ls_wdata = '0;
    logic        ls_gnt, ls_rvalid;
    logic [31:0] rdata, addr, data_core_mem;
    logic        we, re;
    logic [31:0] data_mem_core;
    logic [31:0] dm_noise = 32'h0;
    logic [31:0] dm_force = 32'h0;
    logic        dm_force_en = 1'b0;

    int n_checks = 0;
    int n_err    = 0;
    int cyc      = 0;

    mem_arbiter #(.ADDR_WIDTH(32), .MEM_LATENCY(LAT)) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .if_req        (if_req),
        .if_addr       (if_addr),
        .if_gnt        (if_gnt),
        .if_rvalid     (if_rvalid),
        .ls_req        (ls_req),
        .ls_we         (ls_we),
        .ls_addr       (ls_addr),
        .ls_wdata      (ls_wdata),
        .ls_gnt        (ls_gnt),
        .ls_rvalid     (ls_rvalid),
        .rdata         (rdata),
        .addr          (addr),
        .data_core_mem (data_core_mem),
        .we            (we),
        .re            (re),
        .data_mem_core (data_mem_core)
    );

    always #5 clk = ~clk;

    // Memory return bus: garbage every cycle unless the stimulus forces a value
    always @(posedge clk) dm_noise <= $urandom;
    assign data_mem_core = dm_force_en ? dm_force : dm_noise;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h want 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic at_neg();
        @(negedge clk);
    endtask

    // Reference model: each grant books its future bus events into a per-cycle schedule
    logic [1:0]  ev_rv   [RING];
    logic [31:0] ev_rd   [RING];
    logic        ev_re   [RING];
    logic        ev_we   [RING];
    logic        ev_ld   [RING];
    logic [31:0] ev_addr [RING];
    logic [31:0] ev_wd   [RING];
    logic [1:0]  ev_cap  [RING];
    int          m_free;
    logic        m_last_ls;
    logic [31:0] e_addr, e_wd, e_rdata;

    always @(negedge clk) begin : model
        int   s, n;
        logic e_re, e_we, e_ifg, e_lsg, e_ifrv, e_lsrv, win_ls, win_any;
        s = cyc % RING;
        e_re = 1'b0; e_we = 1'b0; e_ifg = 1'b0; e_lsg = 1'b0; e_ifrv = 1'b0; e_lsrv = 1'b0;
        if (!rst_n) begin
            for (int i = 0; i < RING; i++) begin
                ev_rv[i] = 2'd0; ev_re[i] = 1'b0; ev_we[i] = 1'b0; ev_ld[i] = 1'b0; ev_cap[i] = 2'd0;
            end
            e_addr = '0; e_wd = '0; e_rdata = '0; m_free = 0; m_last_ls = 1'b0;
        end else begin
            e_re = ev_re[s];
            e_we = ev_we[s];
            if (ev_ld[s]) begin
                e_addr = ev_addr[s];
                e_wd   = ev_wd[s];
            end
            e_ifrv = (ev_rv[s] == 2'd1);
            e_lsrv = (ev_rv[s] == 2'd2);
            if (ev_rv[s] != 2'd0) e_rdata = ev_rd[s];
            if (ev_cap[s] != 2'd0) begin
                ev_rv[(cyc + 1) % RING] = ev_cap[s];
                ev_rd[(cyc + 1) % RING] = data_mem_core;
            end
            ev_rv[s] = 2'd0; ev_re[s] = 1'b0; ev_we[s] = 1'b0; ev_ld[s] = 1'b0; ev_cap[s] = 2'd0;
            win_any = (cyc >= m_free) && (if_req || ls_req);
`ifdef ARB_RR_EN
            win_ls = (if_req && ls_req) ? ~m_last_ls : ls_req;
`else
            win_ls = ls_req;
`endif
            e_ifg = win_any && !win_ls;
            e_lsg = win_any && win_ls;
            if (win_any) begin
                n = (cyc + 1) % RING;
                ev_ld[n]   = 1'b1;
                ev_addr[n] = win_ls ? ls_addr : if_addr;
                ev_wd[n]   = win_ls ? ls_wdata : e_wd;
                if (win_ls && ls_we) begin
                    ev_we[n] = 1'b1;
                    m_free   = cyc + 2;
                end else begin
                    ev_re[n] = 1'b1;
                    ev_cap[(cyc + 1 + LAT) % RING] = win_ls ? 2'd2 : 2'd1;
                    m_free   = cyc + 2 + LAT;
                end
                m_last_ls = win_ls;
            end
        end
        check("m_if_gnt",    32'(if_gnt),    32'(e_ifg));
        check("m_ls_gnt",    32'(ls_gnt),    32'(e_lsg));
        check("m_re",        32'(re),        32'(e_re));
        check("m_we",        32'(we),        32'(e_we));
        check("m_addr",      addr,           e_addr);
        check("m_wdata",     data_core_mem,  e_wd);
        check("m_rdata",     rdata,          e_rdata);
        check("m_if_rvalid", 32'(if_rvalid), 32'(e_ifrv));
        check("m_ls_rvalid", 32'(ls_rvalid), 32'(e_lsrv));
        cyc++;
    end

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin : stim
        int          ng, prev, gcyc, rv_seen;
        logic        gi, gl, rvc;
        logic [3:0]  order;

        // Reset
        repeat (3) tick();
        at_neg();
        check("rst re", 32'(re), 32'h0);
        check("rst addr", addr, 32'h0);
        check("rst rdata", rdata, 32'h0);
        tick();
        rst_n = 1'b1;

        // IF read 0x100, data DEADBEEF at cycle 1+LAT
        if_req = 1'b1; if_addr = 32'h100;
        at_neg(); check("rd if_gnt", 32'(if_gnt), 32'h1);
        tick(); if_req = 1'b0;
        at_neg(); check("rd re", 32'(re), 32'h1); check("rd addr", addr, 32'h100);
        repeat (LAT) tick();
        dm_force = 32'hDEADBEEF; dm_force_en = 1'b1;
        tick(); dm_force_en = 1'b0;
        at_neg();
        check("rd if_rvalid", 32'(if_rvalid), 32'h1);
        check("rd rdata", rdata, 32'hDEADBEEF);
        tick();

        // LS store 0x40 <- 0x12345678, next grant two cycles later
        ls_req = 1'b1; ls_we = 1'b1; ls_addr = 32'h40; ls_wdata = 32'h12345678;
        at_neg(); check("st ls_gnt", 32'(ls_gnt), 32'h1);
        tick(); ls_req = 1'b0; ls_we = 1'b0;
        at_neg();
        check("st we", 32'(we), 32'h1);
        check("st re", 32'(re), 32'h0);
        check("st wdata", data_core_mem, 32'h12345678);
        check("st addr", addr, 32'h40);
        tick(); if_req = 1'b1; if_addr = 32'h200;
        at_neg();
        check("st next if_gnt", 32'(if_gnt), 32'h1);
        check("st no ls_rvalid", 32'(ls_rvalid), 32'h0);
        tick(); if_req = 1'b0;
        repeat (LAT + 3) tick();

        // Both requesters held, reads only
        if_req = 1'b1; if_addr = 32'h1000; ls_req = 1'b1; ls_we = 1'b0; ls_addr = 32'h2000;
        ng = 0; order = '0;
        for (int k = 0; k < 4 * (LAT + 2) + 2 && ng < 4; k++) begin
            at_neg(); gi = if_gnt; gl = ls_gnt;
            tick();
            if (gl) begin
                order[ng] = 1'b1; ng++; ls_addr = ls_addr + 32'h4;
            end else if (gi) begin
                order[ng] = 1'b0; ng++; if_addr = if_addr + 32'h4;
            end
        end
        if_req = 1'b0; ls_req = 1'b0;
        check("cf grants", 32'(ng), 32'd4);
`ifdef ARB_RR_EN
        check("cf order", 32'(order), 32'h5);
`else
        check("cf order", 32'(order), 32'hF);
`endif
        repeat (LAT + 3) tick();

        // Reset in the middle of a read: no rvalid afterwards
        if_req = 1'b1; if_addr = 32'h300;
        at_neg(); check("rr if_gnt", 32'(if_gnt), 32'h1);
        tick(); if_req = 1'b0;
        tick(); rst_n = 1'b0;
        at_neg();
        check("rr re", 32'(re), 32'h0);
        check("rr addr", addr, 32'h0);
        check("rr rdata", rdata, 32'h0);
        check("rr if_rvalid", 32'(if_rvalid), 32'h0);
        tick(); tick(); rst_n = 1'b1;
        rv_seen = 0;
        repeat (LAT + 3) begin
            at_neg();
            if (if_rvalid || ls_rvalid) rv_seen++;
            tick();
        end
        check("rr no rvalid", 32'(rv_seen), 32'h0);
        if_req = 1'b1; if_addr = 32'h304;
        at_neg(); check("rr new if_gnt", 32'(if_gnt), 32'h1);
        tick(); if_req = 1'b0;
        repeat (LAT + 3) tick();

        // Request raised during WAIT is granted in the rvalid cycle
        if_req = 1'b1; if_addr = 32'h400;
        at_neg(); check("wt if_gnt", 32'(if_gnt), 32'h1);
        tick(); if_req = 1'b0;
        tick(); ls_req = 1'b1; ls_we = 1'b0; ls_addr = 32'h500;
        gcyc = -1; rvc = 1'b0;
        for (int k = 2; k < LAT + 6; k++) begin
            at_neg();
            if (ls_gnt && gcyc < 0) begin
                gcyc = k; rvc = if_rvalid;
            end
            tick();
            if (gcyc >= 0) ls_req = 1'b0;
        end
        ls_req = 1'b0;
        check("wt gnt cycle", 32'(gcyc), 32'(LAT + 2));
        check("wt gnt with rvalid", 32'(rvc), 32'h1);
        repeat (LAT + 3) tick();

        // Back-to-back IF reads
        if_req = 1'b1; if_addr = 32'h600;
        prev = -1; ng = 0;
        for (int k = 0; k < 3 * (LAT + 2) + 1; k++) begin
            at_neg();
            gi = if_gnt;
            if (if_rvalid) check("bb rvalid lat", 32'(k - prev), 32'(LAT + 2));
            if (gi) begin
                if (prev >= 0) check("bb gap", 32'(k - prev), 32'(LAT + 2));
                prev = k; ng++;
            end
            tick();
            if (gi) if_addr = if_addr + 32'h4;
        end
        if_req = 1'b0;
        check("bb grants", 32'(ng), 32'd4);
        repeat (LAT + 3) tick();

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule

// File: doc/mem_arbiter.md
# mem_arbiter

Two-requester arbiter that shares the core's single memory port between instruction fetch (IF, read-only) and load/store (LS, read/write). It sits between the core pipeline and the memory model or memory controller, and drives that port's addr / data_core_mem / we / re signals. It sequences each access through issue and a fixed read-latency wait, and returns read data to the owning requester.

## Interface
- ADDR_WIDTH, 32, address width
- MEM_LATENCY, 1, cycles from the `re` issue cycle to valid `data_mem_core`; legal range 1..15
- clk  input  1  clock, rising edge
- rst_n  input  1  asynchronous active-low reset
- if_req  input  1  fetch request; held until `if_gnt`
- if_addr  input  ADDR_WIDTH  fetch address
- if_gnt  output  1  fetch request accepted (combinational pulse)
- if_rvalid  output  1  fetch data valid on `rdata` (registered pulse)
- ls_req  input  1  load/store request; held until `ls_gnt`
- ls_we  input  1  1 = store, 0 = load
- ls_addr  input  ADDR_WIDTH  load/store address
- ls_wdata  input  32  store data
- ls_gnt  output  1  load/store request accepted (combinational pulse)
- ls_rvalid  output  1  load data valid on `rdata` (registered pulse)
- rdata  output  32  captured read data, shared by both requesters
- addr  output  ADDR_WIDTH  memory address (registered)
- data_core_mem  output  32  memory write data (registered)
- we  output  1  memory write strobe, one cycle
- re  output  1  memory read strobe, one cycle
- data_mem_core  input  32  memory read data

## Operation
- FSM states: IDLE, ISSUE, WAIT.
- **IDLE:** if any request is present, pick a winner. Assert that requester's gnt in the same cycle. Latch owner, addr, wdata and we. Go to ISSUE.
- **ISSUE:** `addr` and `data_core_mem` show the latched values, and exactly one of `we` or `re` is 1.
  - Write: return to IDLE.
  - Read: load lat_cnt = MEM_LATENCY-1 and go to WAIT.
- **WAIT:** `addr` is held and `re` = 0. Decrement lat_cnt each cycle. When lat_cnt == 0:
  - Capture `data_mem_core` into `rdata`.
  - Set the owner's rvalid for the next cycle.
  - Go to IDLE.
- lat_cnt width is $clog2(MEM_LATENCY+1).
- Arbitration only happens in IDLE. Requests raised during ISSUE or WAIT wait their turn, and gnt stays 0.
- `addr` and `data_core_mem` keep their last values between accesses. `rdata` keeps its value until the next capture.
- Default priority on conflict: LS wins over IF.
- Reset, including mid-access: state IDLE, all outputs 0, lat_cnt 0, last_grant = IF. An in-flight read is dropped and produces no rvalid.

## Timing
- Request in IDLE at cycle T:
  - gnt at T.
  - `re`/`we` at T+1.
  - Read data sampled at the end of cycle T+1+MEM_LATENCY.
  - rvalid and `rdata` valid at T+2+MEM_LATENCY.
- A new grant is allowed in the same cycle as rvalid, since the block is back in IDLE.
- Write occupancy is 2 cycles. Read occupancy is MEM_LATENCY+2 cycles.
- Requesters hold req and all payload signals stable until they see gnt. They may change them freely afterwards.

## Configuration
- `ARB_RR_EN` defined: round-robin on simultaneous requests. The requester not named in last_grant wins. last_grant updates on every grant. The first conflict after reset goes to LS.
- `ARB_RR_EN` undefined: fixed priority, LS always wins. The last_grant register is not instantiated.

## Structure
- `mem_arb_pkg` contains:
  - owner_e {OWN_IF, OWN_LS}
  - state_e {IDLE, ISSUE, WAIT}
  - the MEM_LATENCY range limit constant
- One sub-module, `mem_arb_pick`. Inputs: if_req, ls_req, last_grant. Outputs: winner and any. It is purely combinational and is the only place the `ARB_RR_EN` choice is made.

## Test plan
- MEM_LATENCY=2, IF read 0x100 from IDLE at cycle 0:
  - if_gnt at cycle 0.
  - re=1, addr=0x100 at cycle 1.
  - data_mem_core=0xDEADBEEF at cycle 3.
  - if_rvalid=1, rdata=0xDEADBEEF at cycle 4.
- LS store 0x40 ← 0x12345678:
  - ls_gnt at cycle 0.
  - we=1, data_core_mem=0x12345678 at cycle 1.
  - No rvalid pulse.
  - Next grant possible at cycle 2.
- if_req and ls_req both high, held, each doing reads:
  - Without `ARB_RR_EN`: LS is granted every time and IF starves while ls_req stays high.
  - With `ARB_RR_EN`: grants alternate LS, IF, LS, IF.
- rst_n low at cycle 2 of a MEM_LATENCY=3 read:
  - All outputs 0 immediately.
  - No rvalid after reset is released.
  - A new IF request is granted normally.
- Request arrives during WAIT:
  - gnt stays 0 until the rvalid cycle.
  - gnt is asserted in that rvalid cycle.
- MEM_LATENCY=1 back-to-back IF reads:
  - if_gnt every 3 cycles.
  - rvalid at T+3 for each read.
